// File: rtl/dmem_unit.sv
// Data memory with byte/halfword/word access, range and alignment checks and optional wait states.
// Optional saturating fault counter is built when DMEM_FAULT_COUNT_EN is defined.
module dmem_unit #(
    parameter logic [31:0] DATA_BASE   = 32'h10010000,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [15:0] fault_count
);
    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept, do_access, mem_we, bad;
    logic             op_we, op_sign;
    logic [1:0]       op_size;
    logic [31:0]      op_addr, op_wdata;
    logic [31:0]      offset, word, lane_mask, wdata_lanes, load_val;
    logic [IDX_W-1:0] idx;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    assign ready  = (state_q == StIdle);
    assign accept = req && ready;

    // Without wait states the access happens at the acceptance edge straight from the inputs.
    assign op_we     = NO_WAIT ? we       : we_q;
    assign op_size   = NO_WAIT ? size     : size_q;
    assign op_sign   = NO_WAIT ? sign_ext : sign_q;
    assign op_addr   = NO_WAIT ? addr     : addr_q;
    assign op_wdata  = NO_WAIT ? wdata    : wdata_q;
    assign do_access = NO_WAIT ? accept : ((state_q == StBusy) && (cnt_q == 4'd1));

    assign offset = op_addr - DATA_BASE;
    assign idx    = offset[IDX_W+1:2];
    assign bad    = (offset >= SPAN) || (op_size == 2'b11)
                 || ((op_size == 2'b01) && op_addr[0])
                 || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));

    assign word     = mem_q[idx];
    assign byte_sel = 8'(word >> {op_addr[1:0], 3'b000});
    assign half_sel = op_addr[1] ? word[31:16] : word[15:0];
    assign mem_we   = do_access && op_we && !bad && !reset;

    always_comb begin
        lane_mask   = 32'hFFFFFFFF;
        wdata_lanes = op_wdata;
        load_val    = word;
        case (op_size)
            2'b00: begin
                lane_mask   = 32'h000000FF << {op_addr[1:0], 3'b000};
                wdata_lanes = {4{op_wdata[7:0]}};
                load_val    = {{24{op_sign & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                lane_mask   = op_addr[1] ? 32'hFFFF0000 : 32'h0000FFFF;
                wdata_lanes = {2{op_wdata[15:0]}};
                load_val    = {{16{op_sign & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = we;
            size_d  = size;
            sign_d  = sign_ext;
            addr_d  = addr;
            wdata_d = wdata;
        end
        if (!NO_WAIT) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = StBusy;
                        cnt_d   = WS;
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            endcase
        end
        resp_valid_d = do_access;
        fault_d      = do_access && bad;
        rdata_d      = (do_access && !bad && !op_we) ? load_val : 32'h0;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[idx] <= (word & ~lane_mask) | (wdata_lanes & lane_mask);
        end
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;

`ifdef DMEM_FAULT_COUNT_EN
    logic [15:0] fault_count_q, fault_count_d;

    always_comb begin
        fault_count_d = fault_count_q;
        if (fault_d && (fault_count_q != 16'hFFFF)) begin
            fault_count_d = fault_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            fault_count_q <= 16'h0;
        end else begin
            fault_count_q <= fault_count_d;
        end
    end

    assign fault_count = fault_count_q;
`else
    assign fault_count = 16'h0000;
`endif
endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: two instances (0 and 3 wait states) checked against a byte-array model.
module tb_dmem_unit;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          SPAN = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req, we, sx, ready, rv, flt;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, wdata, rdata;
    logic [1:0][15:0] fcnt;

    dmem_unit #(.DATA_BASE(BASE), .DEPTH_WORDS(2048), .WAIT_STATES(0)) u_dut0 (
        .clk_in(clk), .reset(rst[0]), .req(req[0]), .ready(ready[0]), .we(we[0]),
        .size(size[0]), .sign_ext(sx[0]), .addr(addr[0]), .wdata(wdata[0]),
        .resp_valid(rv[0]), .rdata(rdata[0]), .fault(flt[0]), .fault_count(fcnt[0])
    );

    dmem_unit #(.DATA_BASE(BASE), .DEPTH_WORDS(2048), .WAIT_STATES(3)) u_dut3 (
        .clk_in(clk), .reset(rst[1]), .req(req[1]), .ready(ready[1]), .we(we[1]),
        .size(size[1]), .sign_ext(sx[1]), .addr(addr[1]), .wdata(wdata[1]),
        .resp_valid(rv[1]), .rdata(rdata[1]), .fault(flt[1]), .fault_count(fcnt[1])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mb [2][SPAN];
    bit          pend [2];
    int          due [2];
    logic [31:0] exp_rd [2];
    bit          exp_f [2];
    int          acc_cyc [2];
    int          mfc [2];
    logic [31:0] last_rd [2];
    logic        last_f [2];

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: memory as bytes, response computed from the access rules directly.
    task automatic model(input int d, input bit w, input bit [1:0] sz, input bit s,
                         input logic [31:0] a, input logic [31:0] wd, input bit commit,
                         output bit f, output logic [31:0] rd);
        logic [31:0] off;
        logic [31:0] v;
        int n;
        off = a - BASE;
        n = 1 << sz;
        v = 32'h0;
        f = (off >= SPAN) || (sz == 2'd3) || ((a % n) != 0);
        rd = 32'h0;
        if (!f) begin
            if (w) begin
                if (commit) for (int i = 0; i < n; i++) mb[d][int'(off) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][int'(off) + i];
                if (s && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                check($sformatf("ready%0d", d), ready[d],
                      (cyc > acc_cyc[d] && cyc <= acc_cyc[d] + ws(d)) ? 32'd0 : 32'd1);
                if (pend[d] && cyc == due[d]) begin
                    check($sformatf("resp_valid%0d", d), rv[d], 1);
                    check($sformatf("rdata%0d", d), rdata[d], exp_rd[d]);
                    check($sformatf("fault%0d", d), flt[d], exp_f[d]);
`ifdef DMEM_FAULT_COUNT_EN
                    if (exp_f[d] && mfc[d] < 65535) mfc[d]++;
`endif
                    last_rd[d] = rdata[d];
                    last_f[d]  = flt[d];
                    pend[d]    = 0;
                end else begin
                    check($sformatf("no_resp%0d", d), rv[d], 0);
                end
                check($sformatf("fault_count%0d", d), fcnt[d], mfc[d]);
            end
        end
    end

    task automatic issue(input int d, input bit w, input bit [1:0] sz, input bit s,
                         input logic [31:0] a, input logic [31:0] wd, input bit commit);
        bit f;
        logic [31:0] rd;
        bit done;
        int c;
        done = 0;
        @(negedge clk);
        #1;
        req[d] = 1'b1; we[d] = w; size[d] = sz; sx[d] = s; addr[d] = a; wdata[d] = wd;
        for (int k = 0; k < 50 && !done; k++) begin
            if (ready[d]) begin
                c = cyc;
                @(posedge clk);
                done = 1;
                model(d, w, sz, s, a, wd, commit, f, rd);
                acc_cyc[d] = c;
                if (commit) begin
                    if (pend[d]) check("overlap", 1, 0);
                    pend[d] = 1; due[d] = c + ws(d) + 1; exp_rd[d] = rd; exp_f[d] = f;
                end
            end else begin
                @(negedge clk);
                #1;
            end
        end
        #1;
        req[d] = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 60 && pend[d]; k++) @(posedge clk);
        if (pend[d]) begin
            check("resp_timeout", 0, 1);
            pend[d] = 0;
        end
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        pend[d] = 0;
        acc_cyc[d] = -100;
        mfc[d] = 0;
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        @(negedge clk);
        check("rst_ready", ready[d], 1);
        check("rst_resp_valid", rv[d], 0);
        check("rst_rdata", rdata[d], 0);
        check("rst_fault", flt[d], 0);
        check("rst_fault_count", fcnt[d], 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return BASE + $urandom_range(0, 255);
        if (r == 7) return BASE + 32'd8176 + $urandom_range(0, 15);
        if (r == 8) return BASE + 32'd8192 + $urandom_range(0, 15);
        return BASE - $urandom_range(1, 16);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 2'b11; req = '0; we = '0; sx = '0; size = '0; addr = '0; wdata = '0;
        for (int d = 0; d < 2; d++) begin
            pend[d] = 0; acc_cyc[d] = -100; mfc[d] = 0;
        end
        do_reset(0);
        do_reset(1);

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) issue(d, 1, 2, 0, BASE + 32'(4 * w), $urandom, 1);
            for (int w = 2044; w < 2048; w++) issue(d, 1, 2, 0, BASE + 32'(4 * w), $urandom, 1);
            drain(d);
        end

        // Zero-wait back-to-back store/load and sub-word lanes.
        issue(0, 1, 2, 0, BASE, 32'hDEADBEEF, 1);
        issue(0, 0, 2, 0, BASE, 32'h0, 1);
        drain(0); check("lw_deadbeef", last_rd[0], 32'hDEADBEEF);
        issue(0, 1, 0, 0, BASE + 1, 32'h00000012, 1);
        issue(0, 0, 2, 0, BASE, 32'h0, 1);
        drain(0); check("sb_merge", last_rd[0], 32'hDEAD12EF);
        issue(0, 0, 1, 1, BASE + 2, 32'h0, 1);
        drain(0); check("lh_sext", last_rd[0], 32'hFFFFDEAD);
        issue(0, 0, 1, 0, BASE + 2, 32'h0, 1);
        drain(0); check("lh_zext", last_rd[0], 32'h0000DEAD);
        issue(0, 0, 0, 1, BASE, 32'h0, 1);
        drain(0); check("lb_sext", last_rd[0], 32'hFFFFFFEF);

        issue(0, 0, 2, 0, BASE + 2, 32'h0, 1);
        issue(0, 1, 1, 0, BASE + 3, 32'h0000BEEF, 1);
        issue(0, 0, 2, 0, 32'h1000FFFC, 32'h0, 1);
        issue(0, 0, 2, 0, 32'h10012000, 32'h0, 1);
        drain(0);
        check("fault_flag", last_f[0], 1);
        check("fault_rdata", last_rd[0], 0);
`ifdef DMEM_FAULT_COUNT_EN
        check("fault_count_lit", fcnt[0], 16'd4);
`else
        check("fault_count_lit", fcnt[0], 16'd0);
`endif
        issue(0, 0, 2, 0, BASE, 32'h0, 1);
        drain(0); check("mem_unchanged", last_rd[0], 32'hDEAD12EF);

        issue(0, 1, 2, 0, BASE + 32'h1FFC, 32'hCAFEF00D, 1);
        issue(0, 0, 2, 0, BASE + 32'h1FFC, 32'h0, 1);
        drain(0); check("last_word", last_rd[0], 32'hCAFEF00D);
        check("last_word_fault", last_f[0], 0);
        issue(0, 0, 2, 0, BASE, 32'h0, 1);
        drain(0); check("no_alias", last_rd[0], 32'hDEAD12EF);

        // Wait states: a request held while busy is taken at the end of the response cycle.
        issue(1, 0, 2, 0, BASE + 8, 32'h0, 1);
        c0 = acc_cyc[1];
        issue(1, 0, 2, 0, BASE + 12, 32'h0, 1);
        check("held_accept_gap", 32'(acc_cyc[1] - c0), 32'd4);
        drain(1);

        // Reset one cycle after a store is accepted drops it.
        issue(1, 1, 2, 0, BASE + 32'h10, 32'h11111111, 0);
        do_reset(1);
        issue(1, 0, 2, 0, BASE + 32'h10, 32'h0, 1);
        drain(1);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 300; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                issue(d, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), rand_addr(),
                      $urandom, 1);
            end
            drain(d);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
